// File: rtl/regfile_pkg.sv
// Shared sizing and requester encoding for the register-file write-port controller.
package regfile_pkg;
    localparam int NREG = 32;
    localparam int RW   = 5;
    localparam int DW   = 32;

    typedef enum logic {
        REQ_LSU = 1'b0,
        REQ_ALU = 1'b1
    } req_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bitmap: set on issue, clear on write completion, set wins on collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = regfile_pkg::NREG,
    parameter int RW   = regfile_pkg::RW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_set_en,
    input  logic [RW-1:0]   i_set_idx,
    input  logic            i_clr_en,
    input  logic [RW-1:0]   i_clr_idx,
    input  logic [RW-1:0]   i_rs1,
    input  logic [RW-1:0]   i_rs2,
    output logic            o_rs1_pend,
    output logic            o_rs2_pend,
    output logic [NREG-1:0] o_pending
);
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_next;

    // Decode set/clear masks; x0 is never tracked so it can never stall.
    always_comb begin
        w_set = {NREG{1'b0}};
        w_clr = {NREG{1'b0}};
        if (i_set_en && (i_set_idx != {RW{1'b0}})) begin
            w_set[i_set_idx] = 1'b1;
        end else begin
            w_set = {NREG{1'b0}};
        end
        if (i_clr_en) begin
            w_clr[i_clr_idx] = 1'b1;
        end else begin
            w_clr = {NREG{1'b0}};
        end
        w_next = (r_pending & ~w_clr) | w_set;
    end

    // Scoreboard state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= {NREG{1'b0}};
        end else begin
            r_pending <= w_next;
        end
    end

    assign o_rs1_pend = r_pending[i_rs1];
    assign o_rs2_pend = r_pending[i_rs2];
    assign o_pending  = r_pending;
endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file write-port arbiter (LSU over ALU) with RAW scoreboard.
// Optional forwarding outputs are enabled by defining REGFILE_PORT_CTRL_BYPASS_EN.
module regfile_port_ctrl
    import regfile_pkg::*;
#(
    parameter int NREG = regfile_pkg::NREG,
    parameter int RW   = regfile_pkg::RW,
    parameter int DW   = regfile_pkg::DW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_alu_valid,
    input  logic [RW-1:0]   i_alu_rd,
    input  logic [DW-1:0]   i_alu_val,
    output logic            o_alu_ready,
    input  logic            i_lsu_valid,
    input  logic [RW-1:0]   i_lsu_rd,
    input  logic [DW-1:0]   i_lsu_val,
    output logic            o_lsu_ready,
    input  logic            i_issue_valid,
    input  logic [RW-1:0]   i_issue_rd,
    input  logic [RW-1:0]   i_rs1,
    input  logic [RW-1:0]   i_rs2,
    output logic            o_stall,
    output logic [RW-1:0]   o_w_reg_num,
    output logic [DW-1:0]   o_w_val,
    output logic            o_w_en,
`ifdef REGFILE_PORT_CTRL_BYPASS_EN
    output logic            o_byp1,
    output logic            o_byp2,
    output logic [DW-1:0]   o_byp_val,
`endif
    output logic [NREG-1:0] o_pending
);
    logic          r_w_en;
    logic [RW-1:0] r_w_reg_num;
    logic [DW-1:0] r_w_val;
    logic          w_lsu_ready;
    logic          w_alu_ready;
    logic          w_xfer;
    req_e          w_grant;
    logic [RW-1:0] w_sel_rd;
    logic [DW-1:0] w_sel_val;
    logic          w_wr;
    logic          w_rs1_pend;
    logic          w_rs2_pend;

    assign w_lsu_ready = ~i_rst;
    assign w_alu_ready = ~i_lsu_valid;

    // Fixed-priority grant: loads are older in program order, so LSU wins.
    always_comb begin
        w_xfer    = 1'b0;
        w_grant   = REQ_LSU;
        w_sel_rd  = {RW{1'b0}};
        w_sel_val = {DW{1'b0}};
        if (i_lsu_valid && w_lsu_ready) begin
            w_xfer  = 1'b1;
            w_grant = REQ_LSU;
        end else if (i_alu_valid && w_alu_ready) begin
            w_xfer  = 1'b1;
            w_grant = REQ_ALU;
        end else begin
            w_xfer  = 1'b0;
        end
        case (w_grant)
            REQ_LSU: begin
                w_sel_rd  = i_lsu_rd;
                w_sel_val = i_lsu_val;
            end
            REQ_ALU: begin
                w_sel_rd  = i_alu_rd;
                w_sel_val = i_alu_val;
            end
            default: begin
                w_sel_rd  = {RW{1'b0}};
                w_sel_val = {DW{1'b0}};
            end
        endcase
        w_wr = w_xfer && (w_sel_rd != {RW{1'b0}});
    end

    // One-cycle write register; writes to x0 are accepted but dropped here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_w_en      <= 1'b0;
            r_w_reg_num <= {RW{1'b0}};
            r_w_val     <= {DW{1'b0}};
        end else if (w_wr) begin
            r_w_en      <= 1'b1;
            r_w_reg_num <= w_sel_rd;
            r_w_val     <= w_sel_val;
        end else begin
            r_w_en      <= 1'b0;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .RW   (RW)
    ) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set_en   (i_issue_valid),
        .i_set_idx  (i_issue_rd),
        .i_clr_en   (r_w_en),
        .i_clr_idx  (r_w_reg_num),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .o_rs1_pend (w_rs1_pend),
        .o_rs2_pend (w_rs2_pend),
        .o_pending  (o_pending)
    );

`ifdef REGFILE_PORT_CTRL_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    // A source being written this cycle is forwarded instead of stalled.
    assign w_byp1    = r_w_en && (r_w_reg_num == i_rs1);
    assign w_byp2    = r_w_en && (r_w_reg_num == i_rs2);
    assign o_stall   = (w_rs1_pend && ~w_byp1) || (w_rs2_pend && ~w_byp2);
    assign o_byp1    = w_byp1;
    assign o_byp2    = w_byp2;
    assign o_byp_val = r_w_val;
`else
    assign o_stall   = w_rs1_pend || w_rs2_pend;
`endif

    assign o_alu_ready = w_alu_ready;
    assign o_lsu_ready = w_lsu_ready;
    assign o_w_en      = r_w_en;
    assign o_w_reg_num = r_w_reg_num;
    assign o_w_val     = r_w_val;
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Table-driven bench for regfile_port_ctrl; write-port results go through an expectation queue.
module tb_regfile_port_ctrl;
`ifdef REGFILE_PORT_CTRL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alu_valid, lsu_valid, issue_valid;
    logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1, rs2;
    logic [31:0] alu_val, lsu_val;
    logic        alu_ready, lsu_ready, stall, w_en;
    logic [4:0]  w_reg_num;
    logic [31:0] w_val, pending;
`ifdef REGFILE_PORT_CTRL_BYPASS_EN
    logic        byp1, byp2;
    logic [31:0] byp_val;
`endif

    regfile_port_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alu_valid   (alu_valid),
        .i_alu_rd      (alu_rd),
        .i_alu_val     (alu_val),
        .o_alu_ready   (alu_ready),
        .i_lsu_valid   (lsu_valid),
        .i_lsu_rd      (lsu_rd),
        .i_lsu_val     (lsu_val),
        .o_lsu_ready   (lsu_ready),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_rs1         (rs1),
        .i_rs2         (rs2),
        .o_stall       (stall),
        .o_w_reg_num   (w_reg_num),
        .o_w_val       (w_val),
        .o_w_en        (w_en),
`ifdef REGFILE_PORT_CTRL_BYPASS_EN
        .o_byp1        (byp1),
        .o_byp2        (byp2),
        .o_byp_val     (byp_val),
`endif
        .o_pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, av, lv, iv;
        logic [4:0]  ard, lrd, ird, rs1, rs2;
        logic [31:0] aval, lval;
        logic        e_ar, e_lr, chk_sb, e_stall, e_b1, e_b2;
        logic [31:0] e_pend;
        logic        n_en, n_full;
        logic [4:0]  n_rd;
        logic [31:0] n_val;
    } vec_t;

    typedef struct {
        logic        en, full;
        logic [4:0]  rd;
        logic [31:0] val;
    } wexp_t;

    vec_t  tbl[$];
    wexp_t wq[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    function automatic vec_t mk(int r, int av, int ard, int aval, int lv, int lrd, int lval,
                                int iv, int ird, int s1, int s2,
                                int ar, int lr, int chk, int st, int pend, int b1, int b2,
                                int nen, int nrd, int nval, int nfull);
        vec_t v;
        v.rst = 1'(r);   v.av = 1'(av);   v.ard = 5'(ard);   v.aval = 32'(aval);
        v.lv = 1'(lv);   v.lrd = 5'(lrd); v.lval = 32'(lval);
        v.iv = 1'(iv);   v.ird = 5'(ird); v.rs1 = 5'(s1);    v.rs2 = 5'(s2);
        v.e_ar = 1'(ar); v.e_lr = 1'(lr); v.chk_sb = 1'(chk); v.e_stall = 1'(st);
        v.e_pend = 32'(pend); v.e_b1 = 1'(b1); v.e_b2 = 1'(b2);
        v.n_en = 1'(nen); v.n_rd = 5'(nrd); v.n_val = 32'(nval); v.n_full = 1'(nfull);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        int nb;
        nb = BYP ? 0 : 1;
        //              rst av ard aval         lv lrd lval    iv ird rs1 rs2 | ar lr chk st pend        b1 b2 | nen nrd nval         full
        tbl.push_back(mk(1, 1, 1,  'hAAAA,      1, 2,  'hBBBB, 1, 3,  0,  0,   0, 0, 0,  0, 0,          0, 0,   0,  0,  0,           1));
        tbl.push_back(mk(1, 1, 1,  'hAAAA,      1, 2,  'hBBBB, 1, 3,  3,  0,   0, 0, 1,  0, 0,          0, 0,   0,  0,  0,           1));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  0,  0,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           1));
        tbl.push_back(mk(0, 1, 5,  'hDEADBEEF,  0, 0,  0,      0, 0,  0,  0,   1, 1, 1,  0, 0,          0, 0,   1,  5,  'hDEADBEEF,  1));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  0,  0,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 1, 3,  'h11,        1, 4,  'h22,   0, 0,  0,  0,   0, 1, 1,  0, 0,          0, 0,   1,  4,  'h22,        1));
        tbl.push_back(mk(0, 1, 3,  'h11,        0, 0,  0,      0, 0,  0,  0,   1, 1, 1,  0, 0,          0, 0,   1,  3,  'h11,        1));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  0,  0,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      1, 7,  0,  0,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  7,  0,   1, 1, 1,  1, 'h80,       0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  7,  0,   1, 1, 1,  1, 'h80,       0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 1, 7,  'h77,        0, 0,  0,      0, 0,  7,  0,   1, 1, 1,  1, 'h80,       0, 0,   1,  7,  'h77,        1));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  7,  0,   1, 1, 1,  nb, 'h80,      1, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  7,  0,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      1, 9,  0,  9,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 1, 9,  'h99,        0, 0,  0,      0, 0,  0,  9,   1, 1, 1,  1, 'h200,      0, 0,   1,  9,  'h99,        1));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      1, 9,  0,  9,   1, 1, 1,  nb, 'h200,     0, 1,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  0,  9,   1, 1, 1,  1, 'h200,      0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           1, 9,  'h1234, 0, 0,  0,  9,   0, 1, 1,  1, 'h200,      0, 0,   1,  9,  'h1234,      1));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  0,  9,   1, 1, 1,  nb, 'h200,     0, 1,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  0,  9,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 1, 0,  'hFFFF,      0, 0,  0,      1, 0,  0,  0,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  0,  0,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      1, 12, 12, 0,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      1, 12, 12, 0,   1, 1, 1,  1, 'h1000,     0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 1, 12, 'hC,         0, 0,  0,      0, 0,  12, 0,   1, 1, 1,  1, 'h1000,     0, 0,   1,  12, 'hC,         1));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  12, 0,   1, 1, 1,  nb, 'h1000,    1, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  12, 0,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));
        tbl.push_back(mk(0, 1, 6,  'h66,        0, 0,  0,      1, 20, 0,  0,   1, 1, 1,  0, 0,          0, 0,   1,  6,  'h66,        1));
        tbl.push_back(mk(1, 1, 6,  'h67,        0, 0,  0,      0, 0,  0,  0,   1, 0, 1,  0, 'h100000,   0, 0,   0,  0,  0,           1));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,      0, 0,  0,  0,   1, 1, 1,  0, 0,          0, 0,   0,  0,  0,           0));

        rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        alu_rd = 5'd0; lsu_rd = 5'd0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        alu_val = 32'd0; lsu_val = 32'd0;

        for (int i = 0; i < tbl.size(); i++) begin
            wexp_t e;
            @(negedge clk);
            cyc = i;
            rst = tbl[i].rst;  alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_val = tbl[i].aval;
            lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_val = tbl[i].lval;
            issue_valid = tbl[i].iv; issue_rd = tbl[i].ird; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
            #1;
            chk("alu_ready", {31'd0, alu_ready}, {31'd0, tbl[i].e_ar});
            chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, tbl[i].e_lr});
            if (tbl[i].chk_sb) begin
                chk("stall", {31'd0, stall}, {31'd0, tbl[i].e_stall});
                chk("pending", pending, tbl[i].e_pend);
`ifdef REGFILE_PORT_CTRL_BYPASS_EN
                chk("byp1", {31'd0, byp1}, {31'd0, tbl[i].e_b1});
                chk("byp2", {31'd0, byp2}, {31'd0, tbl[i].e_b2});
                if (byp1 || byp2) chk("byp_val", byp_val, w_val);
`endif
            end
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("w_en", {31'd0, w_en}, {31'd0, e.en});
                if (e.en || e.full) begin
                    chk("w_reg_num", {27'd0, w_reg_num}, {27'd0, e.rd});
                    chk("w_val", w_val, e.val);
                end
            end
            e.en = tbl[i].n_en; e.rd = tbl[i].n_rd; e.val = tbl[i].n_val; e.full = tbl[i].n_full;
            wq.push_back(e);
        end

        @(negedge clk);
        cyc = tbl.size();
        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        #1;
        while (wq.size() > 0) begin
            wexp_t e;
            e = wq.pop_front();
            chk("w_en", {31'd0, w_en}, {31'd0, e.en});
            if (e.en || e.full) begin
                chk("w_reg_num", {27'd0, w_reg_num}, {27'd0, e.rd});
                chk("w_val", w_val, e.val);
            end
        end
        chk("pending_final", pending, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
